// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the nibble-serial borrow-lookahead subtractor.
//   CLA_NIBBLE      : bits processed per RUN cycle
//   cla_sub_state_t : control FSM states (IDLE, RUN, DONE)
//   slice_count()   : number of nibble slices for a given operand width
//   cnt_width()     : slice counter width, never less than one bit
// ---------------------------------------------------------------------------
package cla_pkg;

    localparam int CLA_NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cla_sub_state_t;

    function automatic int slice_count(input int width);
        return width / CLA_NIBBLE;
    endfunction

    function automatic int cnt_width(input int slices);
        return (slices > 1) ? $clog2(slices) : 1;
    endfunction

endpackage

// File: rtl/cla4_cin.sv
// ---------------------------------------------------------------------------
// cla4_cin
// 4-bit carry-lookahead adder with carry-in and carry-out. Every carry is
// expanded as a flat sum of products of generate/propagate terms, so no
// carry ripples from one bit position into the next.
// Ports:
//   a, b : 4-bit addends
//   cin  : carry into bit 0
//   sum  : 4-bit sum
//   cout : carry out of bit 3
// ---------------------------------------------------------------------------
module cla4_cin (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] p_s;
    logic [3:0] g_s;
    logic       c1_s;
    logic       c2_s;
    logic       c3_s;
    logic       c4_s;

    // Propagate / generate terms per bit position
    always_comb begin
        p_s = a ^ b;
        g_s = a & b;
    end

    // Fully expanded lookahead carries, each a two-level function of p, g, cin
    always_comb begin
        c1_s = g_s[0]
             | (p_s[0] & cin);
        c2_s = g_s[1]
             | (p_s[1] & g_s[0])
             | (p_s[1] & p_s[0] & cin);
        c3_s = g_s[2]
             | (p_s[2] & g_s[1])
             | (p_s[2] & p_s[1] & g_s[0])
             | (p_s[2] & p_s[1] & p_s[0] & cin);
        c4_s = g_s[3]
             | (p_s[3] & g_s[2])
             | (p_s[3] & p_s[2] & g_s[1])
             | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
             | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);
    end

    // Sum bits from propagate and the carry into each position
    always_comb begin
        sum  = p_s ^ {c3_s, c2_s, c1_s, cin};
        cout = c4_s;
    end

endmodule

// File: rtl/cla_serial_subtractor.sv
// ---------------------------------------------------------------------------
// cla_serial_subtractor
// Nibble-serial subtractor: diff = a - b (mod 2^WIDTH), one 4-bit slice per
// cycle, LSB first, through a single borrow-lookahead stage (cla4_cin fed
// with ~b and ~borrow). A registered borrow links consecutive slices.
// Optional feature macro: CLA_SUB_OVERFLOW_EN adds the signed overflow port.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready depends on state only)
//   a, b                : minuend, subtrahend (WIDTH bits)
//   out_valid/out_ready : result handshake, result held until accepted
//   diff                : a - b mod 2^WIDTH
//   borrow_out          : 1 when a < b unsigned
//   busy                : high in RUN or DONE
//   overflow            : signed overflow (only with CLA_SUB_OVERFLOW_EN)
// Parameter:
//   WIDTH : operand width, multiple of 4, at least 4
// ---------------------------------------------------------------------------
module cla_serial_subtractor
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy
`ifdef CLA_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int N  = slice_count(WIDTH);
    localparam int CW = cnt_width(N);

    cla_sub_state_t   state_r;
    cla_sub_state_t   state_next_s;
    logic             load_s;
    logic             step_s;
    logic             last_slice_s;

    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             borrow_r;
    logic [WIDTH-1:0] diff_r;
    logic [WIDTH-1:0] diff_next_s;
    logic             out_valid_r;
    logic             busy_r;
    logic             in_ready_r;

    logic [3:0]       slice_sum_s;
    logic             slice_cout_s;

`ifdef CLA_SUB_OVERFLOW_EN
    logic             a_msb_r;
    logic             b_msb_r;
    logic             overflow_r;
`endif

    // Subtraction as a + ~b + ~borrow on the current low nibble of the
    // shifting operand registers
    cla4_cin u_cla4 (
        .a    (a_r[3:0]),
        .b    (~b_r[3:0]),
        .cin  (~borrow_r),
        .sum  (slice_sum_s),
        .cout (slice_cout_s)
    );

    // Shift each new slice result in from the top; after N slices the
    // first slice has reached bit 0
    generate
        if (WIDTH > CLA_NIBBLE) begin : g_wide
            assign diff_next_s = {slice_sum_s, diff_r[WIDTH-1:CLA_NIBBLE]};
        end else begin : g_narrow
            assign diff_next_s = slice_sum_s;
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and datapath controls
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        last_slice_s = (cnt_r == CW'(N - 1));
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    load_s       = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (last_slice_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Handshake/status flags registered from the next state so they are
    // glitch-free and depend on state only
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            out_valid_r <= (state_next_s == DONE);
            busy_r      <= (state_next_s == RUN) || (state_next_s == DONE);
            in_ready_r  <= (state_next_s == IDLE);
        end
    end

    // Operand shift registers, slice counter, borrow link and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= '0;
            a_r      <= '0;
            b_r      <= '0;
            borrow_r <= 1'b0;
            diff_r   <= '0;
        end else if (load_s) begin
            cnt_r    <= '0;
            a_r      <= a;
            b_r      <= b;
            borrow_r <= 1'b0;
        end else if (step_s) begin
            cnt_r    <= cnt_r + CW'(1);
            a_r      <= a_r >> CLA_NIBBLE;
            b_r      <= b_r >> CLA_NIBBLE;
            borrow_r <= ~slice_cout_s;
            diff_r   <= diff_next_s;
        end else begin
            cnt_r    <= cnt_r;
            a_r      <= a_r;
            b_r      <= b_r;
            borrow_r <= borrow_r;
            diff_r   <= diff_r;
        end
    end

`ifdef CLA_SUB_OVERFLOW_EN
    // Signed overflow: operand signs differ and the result sign differs from
    // the minuend; the original MSBs are kept since the operands shift away
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb_r    <= 1'b0;
            b_msb_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else if (load_s) begin
            a_msb_r    <= a[WIDTH-1];
            b_msb_r    <= b[WIDTH-1];
            overflow_r <= overflow_r;
        end else if (step_s && last_slice_s) begin
            a_msb_r    <= a_msb_r;
            b_msb_r    <= b_msb_r;
            overflow_r <= (a_msb_r ^ b_msb_r) & (a_msb_r ^ slice_sum_s[3]);
        end else begin
            a_msb_r    <= a_msb_r;
            b_msb_r    <= b_msb_r;
            overflow_r <= overflow_r;
        end
    end

    assign overflow = overflow_r;
`endif

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;
    assign diff       = diff_r;
    assign borrow_out = borrow_r;

endmodule
